// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction-fetch stage.
//
// Owns the PC and the DE pipeline latches. Each cycle it presents the PC to
// the I-cache, loads the DE latches unless decode or MEM is stalled, and
// advances, holds or redirects the PC.
//
// Ports:
//   clk, reset         - clock; synchronous active-high reset
//   icache_addr        - current PC driven to the I-cache
//   icache_r           - I-cache ready, icache_data valid this cycle
//   icache_data        - instruction word at icache_addr
//   dep_stall          - decode dependency stall
//   mem_stall          - MEM stage stall (D-cache miss)
//   v_de_br_stall      - valid control instruction in DE
//   v_agex_br_stall    - valid control instruction in AGEX
//   v_mem_br_stall     - valid control instruction in MEM
//   mem_pcmux          - 0 = PC+2, 1 = target_pc, 2 = trap_pc, 3 = as 0
//   target_pc, trap_pc - redirect sources from MEM
//   de_npc, de_ir, de_v - DE latch contents
//   fetch_count        - valid instructions delivered to DE
//   bubble_count       - DE loads that carried a bubble
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [15:0]      icache_addr,
    input  logic             icache_r,
    input  logic [15:0]      icache_data,
    input  logic             dep_stall,
    input  logic             mem_stall,
    input  logic             v_de_br_stall,
    input  logic             v_agex_br_stall,
    input  logic             v_mem_br_stall,
    input  logic [1:0]       mem_pcmux,
    input  logic [15:0]      target_pc,
    input  logic [15:0]      trap_pc,
    output logic [15:0]      de_npc,
    output logic [15:0]      de_ir,
    output logic             de_v,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count
);

    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [15:0] pc_next;
    logic        any_br_stall;
    logic        ld_de;
    logic        new_de_v;

    assign icache_addr  = pc;
    assign pc_plus2     = pc + 16'd2;
    assign any_br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
    assign ld_de        = ~dep_stall & ~mem_stall;
    assign new_de_v     = icache_r & ~any_br_stall;

    // A redirect from MEM wins over every stall and over an I-cache miss;
    // instruction addresses are halfword aligned, so bit 0 is cleared.
    always_comb begin
        pc_next = pc;
        unique case (mem_pcmux)
            2'd1:    pc_next = target_pc & 16'hFFFE;
            2'd2:    pc_next = trap_pc & 16'hFFFE;
            default: if (new_de_v && ld_de) pc_next = pc_plus2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            de_npc       <= '0;
            de_ir        <= '0;
            de_v         <= 1'b0;
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            pc <= pc_next;
            if (ld_de) begin
                de_npc <= pc_plus2;
                de_ir  <= icache_data;
                de_v   <= new_de_v;
                if (new_de_v) fetch_count  <= fetch_count + CNT_W'(1);
                else          bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Stimulus computes the
// expected post-edge state from a reference model and queues it; a monitor
// pops one entry per clock edge and compares it with the DUT.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h3000;
    localparam int unsigned CNT_W    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [15:0]      icache_addr;
    logic             icache_r = 1'b0;
    logic [15:0]      icache_data = '0;
    logic             dep_stall = 1'b0;
    logic             mem_stall = 1'b0;
    logic             v_de_br_stall = 1'b0;
    logic             v_agex_br_stall = 1'b0;
    logic             v_mem_br_stall = 1'b0;
    logic [1:0]       mem_pcmux = '0;
    logic [15:0]      target_pc = '0;
    logic [15:0]      trap_pc = '0;
    logic [15:0]      de_npc;
    logic [15:0]      de_ir;
    logic             de_v;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] bubble_count;

    fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .icache_addr(icache_addr),
        .icache_r(icache_r), .icache_data(icache_data),
        .dep_stall(dep_stall), .mem_stall(mem_stall),
        .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
        .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux),
        .target_pc(target_pc), .trap_pc(trap_pc),
        .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        r;
        logic [15:0] data;
        logic        dep;
        logic        mst;
        logic        vde;
        logic        vag;
        logic        vme;
        logic [1:0]  pcmux;
        logic [15:0] tgt;
        logic [15:0] trp;
    } stim_t;

    typedef struct packed {
        logic [15:0]      pc;
        logic [15:0]      npc;
        logic [15:0]      ir;
        logic             v;
        logic [CNT_W-1:0] fc;
        logic [CNT_W-1:0] bc;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state (what the stage should hold after each edge).
    logic [15:0]      m_pc;
    logic [15:0]      m_npc;
    logic [15:0]      m_ir;
    logic             m_v;
    logic [CNT_W-1:0] m_fc;
    logic [CNT_W-1:0] m_bc;

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.r     = 1'b1;
        s.data  = 16'($urandom);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        logic        blocked;
        logic        deliver;
        exp_t        e;
        @(negedge clk);
        reset           = s.rst;
        icache_r        = s.r;
        icache_data     = s.data;
        dep_stall       = s.dep;
        mem_stall       = s.mst;
        v_de_br_stall   = s.vde;
        v_agex_br_stall = s.vag;
        v_mem_br_stall  = s.vme;
        mem_pcmux       = s.pcmux;
        target_pc       = s.tgt;
        trap_pc         = s.trp;
        if (s.rst) begin
            m_pc = RESET_PC; m_npc = '0; m_ir = '0; m_v = 1'b0;
            m_fc = '0; m_bc = '0;
        end else begin
            // Instruction is usable only if the cache hit and no control
            // instruction is in flight; DE only moves when nothing stalls.
            deliver = s.r && !(s.vde || s.vag || s.vme);
            blocked = s.dep || s.mst;
            if (!blocked) begin
                m_npc = m_pc + 16'd2;
                m_ir  = s.data;
                m_v   = deliver;
                if (deliver) m_fc = m_fc + 1'b1;
                else         m_bc = m_bc + 1'b1;
            end
            if (s.pcmux == 2'd1)      m_pc = {s.tgt[15:1], 1'b0};
            else if (s.pcmux == 2'd2) m_pc = {s.trp[15:1], 1'b0};
            else if (deliver && !blocked) m_pc = m_pc + 16'd2;
        end
        e.pc = m_pc; e.npc = m_npc; e.ir = m_ir; e.v = m_v;
        e.fc = m_fc; e.bc = m_bc;
        expq.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one expected state per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("icache_addr",  32'(icache_addr),  32'(e.pc));
                check("de_npc",       32'(de_npc),       32'(e.npc));
                check("de_ir",        32'(de_ir),        32'(e.ir));
                check("de_v",         32'(de_v),         32'(e.v));
                check("fetch_count",  32'(fetch_count),  32'(e.fc));
                check("bubble_count", 32'(bubble_count), 32'(e.bc));
            end
        end
    end

    initial begin
        stim_t s;
        int    budget;
        m_pc = '0; m_npc = '0; m_ir = '0; m_v = 1'b0; m_fc = '0; m_bc = '0;

        // Reset
        s = idle(); s.rst = 1'b1; apply(s); apply(s);
        // Straight-line fetch
        s = idle(); s.data = 16'h1234; apply(s);
        s = idle(); s.data = 16'h5678; apply(s);
        // dep_stall for 3 cycles at 0x3004, then resume
        for (int i = 0; i < 3; i++) begin s = idle(); s.dep = 1'b1; apply(s); end
        s = idle(); apply(s);
        s = idle(); apply(s);
        // I-cache miss for 2 cycles at 0x3008
        for (int i = 0; i < 2; i++) begin s = idle(); s.r = 1'b0; apply(s); end
        s = idle(); apply(s);
        // Branch through DE, AGEX, MEM with redirect to 0x4001 -> 0x4000
        s = idle(); s.vde = 1'b1; apply(s);
        s = idle(); s.vag = 1'b1; apply(s);
        s = idle(); s.vme = 1'b1; s.pcmux = 2'd1; s.tgt = 16'h4001; apply(s);
        s = idle(); apply(s);
        // TRAP redirect during mem_stall
        s = idle(); s.mst = 1'b1; s.vme = 1'b1; s.pcmux = 2'd2; s.trp = 16'h0200; apply(s);
        s = idle(); apply(s);
        // pcmux 3 behaves as sequential
        s = idle(); s.pcmux = 2'd3; s.tgt = 16'h1110; s.trp = 16'h2220; apply(s);
        // Wrap: redirect to 0xFFFE then fetch
        s = idle(); s.vme = 1'b1; s.pcmux = 2'd1; s.tgt = 16'hFFFE; apply(s);
        s = idle(); apply(s);
        s = idle(); apply(s);
        // Reset during dep_stall and during a miss
        s = idle(); s.dep = 1'b1; apply(s);
        s = idle(); s.dep = 1'b1; s.rst = 1'b1; apply(s);
        s = idle(); s.r = 1'b0; s.rst = 1'b1; s.pcmux = 2'd1; s.tgt = 16'h5550; apply(s);
        s = idle(); apply(s);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s       = '0;
            s.rst   = ($urandom_range(0, 199) == 0);
            s.r     = ($urandom_range(0, 3) != 0);
            s.data  = 16'($urandom);
            s.dep   = ($urandom_range(0, 4) == 0);
            s.mst   = ($urandom_range(0, 6) == 0);
            s.vde   = ($urandom_range(0, 6) == 0);
            s.vag   = ($urandom_range(0, 6) == 0);
            s.vme   = ($urandom_range(0, 6) == 0);
            s.pcmux = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            s.tgt   = 16'($urandom);
            s.trp   = 16'($urandom);
            apply(s);
        end

        budget = 0;
        while (expq.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (expq.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LC-3b pipeline, directly upstream of the decode stage.
- Owns the PC and the DE pipeline latches (de_npc, de_ir, de_v).
- Reads the instruction cache each cycle and honours decode/memory stalls and control-flow stalls.
- Accepts PC redirects (taken branch, JMP/JSR target, TRAP vector) resolved in the MEM stage.
- Keeps two debug counters for fetched instructions and bubbles.

Parameters:
- RESET_PC, 16'h3000: PC value loaded on reset.
- CNT_W, 16: width of the debug counters fetch_count and bubble_count.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- icache_addr  output  16  current PC driven to the I-cache
- icache_r  input  1  I-cache ready; icache_data is valid this cycle
- icache_data  input  16  instruction word at icache_addr
- dep_stall  input  1  decode dependency stall
- mem_stall  input  1  MEM stage stall (D-cache miss)
- v_de_br_stall  input  1  valid control instruction in DE
- v_agex_br_stall  input  1  valid control instruction in AGEX
- v_mem_br_stall  input  1  valid control instruction in MEM
- mem_pcmux  input  2  0 = PC+2, 1 = target_pc, 2 = trap_pc, 3 = reserved (treated as 0)
- target_pc  input  16  branch/JMP/JSR target from MEM
- trap_pc  input  16  TRAP vector data from MEM
- de_npc  output  16  PC+2 of the instruction in the DE latch
- de_ir  output  16  instruction in the DE latch
- de_v  output  1  DE latch valid
- fetch_count  output  CNT_W  instructions delivered to DE (valid loads)
- bubble_count  output  CNT_W  cycles in which DE was loaded with a bubble

Behaviour:
- Reset values: pc = RESET_PC; de_npc = 0, de_ir = 0, de_v = 0; both counters = 0. Reset overrides every other input in the same cycle.
- icache_addr = pc (combinational). pc_plus2 = pc + 2, mod 2^16; 16'hFFFE wraps to 16'h0000.
- any_br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall.
- ld_de = ~dep_stall & ~mem_stall. When ld_de = 0, all DE latches hold.
- When ld_de = 1:
  - de_npc <= pc_plus2
  - de_ir <= icache_data
  - de_v <= icache_r & ~any_br_stall
- Redirect: mem_pcmux of 1 or 2 is a redirect.
  - pc <= target_pc (pcmux 1) or trap_pc (pcmux 2), with bit 0 forced to 0.
  - A redirect loads pc unconditionally, with priority over all stalls and over icache_r.
- Sequential advance (mem_pcmux = 0 or 3): pc <= pc_plus2 only when icache_r & ~any_br_stall & ~dep_stall & ~mem_stall. Otherwise pc holds.
- Redirect in the same cycle as ld_de: DE takes a bubble, since v_mem_br_stall is high whenever MEM resolves a branch. The target instruction is fetched in the next cycle.
- I-cache miss (icache_r = 0) with ld_de = 1: DE receives a bubble (de_v = 0) and pc holds until icache_r returns.
- Latency: one cycle from a PC value to the corresponding DE latch.
- Counters:
  - Both counters update only when ld_de = 1.
  - fetch_count increments when the new de_v is 1; bubble_count increments when the new de_v is 0.
  - Both wrap at 2^CNT_W, with no saturation.
- Reset asserted mid-stall or mid-miss: state returns to reset values next edge; stall inputs are ignored that cycle.

Test Plan:
- Reset, then straight-line fetch: icache_r = 1, no stalls, icache_data = 16'h1234/16'h5678. Required: de_ir = 16'h1234, de_npc = 16'h3002, de_v = 1 after first edge; then 16'h5678 / 16'h3004; fetch_count = 2.
- dep_stall held 3 cycles at pc = 16'h3004: de_ir/de_npc/de_v and pc unchanged for 3 cycles, counters frozen. Resumes with de_npc = 16'h3006.
- I-cache miss: icache_r = 0 for 2 cycles at pc = 16'h3008. Required: de_v = 0 twice, bubble_count + 2, pc held at 16'h3008. After icache_r = 1, de_npc = 16'h300A.
- Branch flow: v_de_br_stall, then v_agex_br_stall, then v_mem_br_stall with mem_pcmux = 1, target_pc = 16'h4001. Required: 3 bubbles, pc = 16'h4000 after the redirect edge, next de_npc = 16'h4002 with de_v = 1.
- TRAP redirect during mem_stall: mem_pcmux = 2, trap_pc = 16'h0200, mem_stall = 1. Required: pc = 16'h0200, DE latches unchanged.
- Wrap and reset: pc = 16'hFFFE fetch gives de_npc = 16'h0000. Asserting reset during a dep_stall gives pc = 16'h3000, de_v = 0, counters = 0 on the next edge.
